// File: rtl/jstk_move_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : jstk_move_ctrl
// Brief    : Joystick input conditioner. Synchronizes and debounces a raw
//            3-bit joystick code, then turns the accepted direction into
//            move strobes with typematic auto-repeat and a button strobe.
// Revision : 1.0  initial release
// ============================================================================
module jstk_move_ctrl #(
  parameter int DB_CYC  = 4,
  parameter int DLY_CYC = 12,
  parameter int RPT_CYC = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] JSTK_AXIS,
  output logic       move,
  output logic       move_x,
  output logic       move_y,
  output logic       btn,
  output logic [7:0] LED,
  output logic [7:0] move_cnt
);

  localparam int C_DW   = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
  localparam int C_TMAX = (DLY_CYC > RPT_CYC) ? DLY_CYC : RPT_CYC;
  localparam int C_TW   = (C_TMAX > 1) ? $clog2(C_TMAX) : 1;

  localparam logic [C_DW-1:0] C_DB_LAST  = C_DW'(DB_CYC - 1);
  localparam logic [C_TW-1:0] C_DLY_LOAD = C_TW'(DLY_CYC - 1);
  localparam logic [C_TW-1:0] C_RPT_LOAD = C_TW'(RPT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } state_t;

  logic [2:0]      sync1_q, sync2_q;
  logic [2:0]      cand_q;
  logic [C_DW-1:0] dbcnt_q;
  logic [2:0]      acc_q;

  state_t          state_q, state_d;
  logic [C_TW-1:0] tmr_q, tmr_d;
  logic            strobe_d;

  logic            move_q, move_x_q, move_y_q, btn_q;
  logic [7:0]      led_q, cnt_q;

  logic [1:0]      w_dir;
  logic            w_change;

  assign w_dir    = acc_q[1:0];
  assign w_change = (w_dir != {move_y_q, move_x_q});

  // Two-flop synchronizer followed by a saturating stability counter; the
  // candidate is accepted only once it has matched the input for DB_CYC
  // consecutive cycles and still matches on the accepting cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 3'b000;
      sync2_q <= 3'b000;
      cand_q  <= 3'b000;
      dbcnt_q <= '0;
      acc_q   <= 3'b000;
    end else begin
      sync1_q <= JSTK_AXIS;
      sync2_q <= sync1_q;
      if (cand_q != sync2_q) begin
        cand_q  <= sync2_q;
        dbcnt_q <= '0;
      end else if (dbcnt_q != C_DB_LAST) begin
        dbcnt_q <= dbcnt_q + C_DW'(1);
      end else begin
        acc_q   <= cand_q;
      end
    end
  end

  // Auto-repeat state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
    end
  end

  // Next-state logic: a new or changed direction strobes at once and
  // restarts the initial delay; a held direction strobes on timer expiry.
  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    strobe_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (w_dir != 2'b00) begin
          strobe_d = 1'b1;
          tmr_d    = C_DLY_LOAD;
          state_d  = DELAY;
        end
      end
      DELAY, REPEAT: begin
        if (w_dir == 2'b00) begin
          state_d = IDLE;
        end else if (w_change) begin
          strobe_d = 1'b1;
          tmr_d    = C_DLY_LOAD;
          state_d  = DELAY;
        end else if (tmr_q == '0) begin
          strobe_d = 1'b1;
          tmr_d    = C_RPT_LOAD;
          state_d  = REPEAT;
        end else begin
          tmr_d    = tmr_q - C_TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registered outputs; the direction bits hold between strobes and the
  // button strobe fires on a rising edge of the accepted button bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      move_q   <= 1'b0;
      move_x_q <= 1'b0;
      move_y_q <= 1'b0;
      btn_q    <= 1'b0;
      led_q    <= 8'h00;
      cnt_q    <= 8'h00;
    end else begin
      move_q <= strobe_d;
      if (strobe_d) begin
        move_x_q <= w_dir[0];
        move_y_q <= w_dir[1];
      end
      cnt_q <= cnt_q + 8'(strobe_d);
      btn_q <= acc_q[2] & ~led_q[5];
      led_q <= {acc_q[0], acc_q[1], acc_q[2], 5'b00000};
    end
  end

  assign move     = move_q;
  assign move_x   = move_x_q;
  assign move_y   = move_y_q;
  assign btn      = btn_q;
  assign LED      = led_q;
  assign move_cnt = cnt_q;

endmodule
`default_nettype wire

// File: doc/jstk_move_ctrl.md
JSTK_MOVE_CTRL -- requirements
Module: jstk_move_ctrl

Interface
REQ-001 Parameter DB_CYC, default 4: consecutive stable synchronized cycles required to accept a new joystick code.
REQ-002 Parameter DLY_CYC, default 12: cycles from first move pulse to first auto-repeat pulse.
REQ-003 Parameter RPT_CYC, default 6: cycles between auto-repeat pulses.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst  in  1  reset, asynchronous and active-high.
REQ-006 JSTK_AXIS  in  3  raw joystick code, asynchronous; [0]=X, [1]=Y, [2]=button.
REQ-007 move  out  1  one-cycle move strobe.
REQ-008 move_x  out  1  X component of the current move; valid while move=1, holds otherwise.
REQ-009 move_y  out  1  Y component of the current move; valid while move=1, holds otherwise.
REQ-010 btn  out  1  one-cycle strobe on accepted button press.
REQ-011 LED  out  8  status: [7]=accepted X, [6]=accepted Y, [5]=accepted button, [4:0]=0.
REQ-012 move_cnt  out  8  count of move strobes issued, wraps 255->0.

Function
REQ-013 JSTK_AXIS SHALL pass a 2-flop synchronizer; synchronized value s.
REQ-014 Debouncer: candidate register c, counter; c!=s -> c<=s, counter<=0; else counter increments, saturating at DB_CYC-1.
REQ-015 Accepted code d SHALL load c on the cycle c==s with counter==DB_CYC-1; input held stable -> d updates DB_CYC+2 cycles after the JSTK_AXIS change.
REQ-016 Any change shorter than DB_CYC+1 synchronized cycles SHALL leave d unchanged.
REQ-017 Outputs move, move_x, move_y, btn, LED SHALL be registered; each reflects d one cycle after d updates.
REQ-018 FSM states: IDLE, DELAY, REPEAT; down-counter tmr.
REQ-019 IDLE: d[1:0]!=0 -> move=1 with move_x/move_y=d[1:0], tmr<=DLY_CYC-1, go DELAY.
REQ-020 DELAY: d[1:0]==0 -> IDLE, no strobe; tmr==0 -> strobe, tmr<=RPT_CYC-1, go REPEAT; else tmr decrements.
REQ-021 REPEAT: d[1:0]==0 -> IDLE, no strobe; tmr==0 -> strobe, tmr<=RPT_CYC-1; else tmr decrements.
REQ-022 DELAY/REPEAT: d[1:0] changes to a different nonzero value -> immediate strobe with new direction, tmr<=DLY_CYC-1, go DELAY; direction change takes priority over timer expiry in the same cycle.
REQ-023 At most one move strobe per cycle; move_cnt increments by 1 on every strobe, modulo 256.
REQ-024 btn SHALL pulse one cycle on each 0->1 transition of d[2], independent of FSM state; a concurrent move strobe is unaffected.
REQ-025 With holding direction H, strobes occur at relative cycles 0, DLY_CYC, DLY_CYC+RPT_CYC, DLY_CYC+2*RPT_CYC, ...

Reset
REQ-026 rst=1 SHALL immediately clear synchronizer, c, debounce counter, d, tmr, move_cnt, and all outputs to 0, and force IDLE.
REQ-027 Reset asserted mid-DELAY/REPEAT SHALL cancel pending strobes; after release, an input still held SHALL re-debounce (DB_CYC+2 cycles) before a strobe.
REQ-028 rst release SHALL cause no strobe while JSTK_AXIS=0.

Verification
REQ-029 JSTK_AXIS 000->001 held 10 cycles -> single move strobe with move_x=1, move_y=0, 7 cycles after change (DB_CYC+2 plus register); LED=8'h80; move_cnt=1.
REQ-030 JSTK_AXIS=010 held 40 cycles -> strobes at relative cycles 0, 12, 18, 24, 30, 36; move_cnt=6; release -> no further strobes; LED returns 8'h00.
REQ-031 JSTK_AXIS glitch 000->001 for 3 cycles, then 000 -> no strobe, LED stays 8'h00, move_cnt=0.
REQ-032 Hold 001 in REPEAT, switch to 011 -> strobe with move_x=1, move_y=1 on the cycle after d updates; next strobe 12 cycles later.
REQ-033 JSTK_AXIS 000->100 held 20 cycles -> exactly one btn pulse, no move strobe, LED=8'h20; 101 -> move and LED=8'hA0, no second btn.
REQ-034 rst pulse in REPEAT with input held at 001 -> all outputs 0 during reset; first strobe DB_CYC+3 cycles after release; move_cnt restarts at 1.
